// File: rtl/mips_multdiv_unit_if.sv
// Bundles the request/result signals of the MIPS HI/LO multiply-divide unit.
// The master issues operations, and the slave (the unit) returns busy, done and HI/LO.
interface mips_multdiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             clk_enable;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output clk_enable, start, op, operand_a, operand_b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  clk_enable, start, op, operand_a, operand_b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mips_multdiv_unit.sv
// Iterative MIPS HI/LO unit: radix-2 shift-add multiply and restoring divide on operand
// magnitudes, with a final sign-fix cycle. MTHI and MTLO write directly from IDLE.
module mips_multdiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic               clk,
  input logic               reset,
  mips_multdiv_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q;
  logic             neg_res, neg_rem, div_zero, op_div;

  logic             busy_w, accept_md, mt_hi_wr, mt_lo_wr, step_last;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] product, prod_fix;
  logic [WIDTH-1:0] res_hi, res_lo;

  // Even opcodes among 000..011 are the signed variants.
  assign a_neg = ~bus.op[0] & bus.operand_a[WIDTH-1];
  assign b_neg = ~bus.op[0] & bus.operand_b[WIDTH-1];
  assign a_mag = a_neg ? -bus.operand_a : bus.operand_a;
  assign b_mag = b_neg ? -bus.operand_b : bus.operand_b;

  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd};

  assign product  = {acc_hi, acc_lo};
  assign prod_fix = neg_res ? -product : product;

  always_comb begin
    res_hi = prod_fix[2*WIDTH-1:WIDTH];
    res_lo = prod_fix[WIDTH-1:0];
    if (op_div) begin
      res_hi = neg_rem ? -acc_hi : acc_hi;
      res_lo = div_zero ? '1 : (neg_res ? -acc_lo : acc_lo);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else if (bus.clk_enable) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start && !bus.op[2]) state_nxt = bus.op[1] ? DIV : MUL;
      MUL, DIV: if (step_last) state_nxt = FIX;
      FIX: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_w    = (state != IDLE);
    accept_md = (state == IDLE) && bus.start && !bus.op[2];
    mt_hi_wr  = (state == IDLE) && bus.start && (bus.op == 3'b100);
    mt_lo_wr  = (state == IDLE) && bus.start && (bus.op == 3'b101);
    step_last = (cnt == CNT_W'(WIDTH - 1));
  end

  // Multiply and divide share the acc_hi:acc_lo pair; opnd holds the multiplicand or divisor.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      op_div   <= 1'b0;
    end else if (bus.clk_enable) begin
      done_q <= (state == FIX);
      if (accept_md) begin
        cnt      <= '0;
        acc_hi   <= '0;
        acc_lo   <= bus.op[1] ? a_mag : b_mag;
        opnd     <= bus.op[1] ? b_mag : a_mag;
        neg_res  <= a_neg ^ b_neg;
        neg_rem  <= a_neg;
        div_zero <= (bus.operand_b == '0);
        op_div   <= bus.op[1];
      end else if (state == MUL) begin
        cnt    <= cnt + 1'b1;
        acc_hi <= mul_sum[WIDTH:1];
        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
      end else if (state == DIV) begin
        cnt <= cnt + 1'b1;
        if (!div_diff[WIDTH]) begin
          acc_hi <= div_diff[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
          acc_hi <= div_shift[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
        end
      end
      if (mt_hi_wr) hi_q <= bus.operand_a;
      if (mt_lo_wr) lo_q <= bus.operand_a;
      if (state == FIX) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end
  end

  assign bus.busy = busy_w;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mips_multdiv_unit.sv
// Directed bench for mips_multdiv_unit: a table of mult/div vectors plus hand-written
// sequences for MTHI/MTLO, no-op, ignored restart, stall and asynchronous reset.
module tb_mips_multdiv_unit;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  vec_t vecs[14];

  mips_multdiv_unit_if #(.WIDTH(32)) bus ();

  mips_multdiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Runs one mult/div from IDLE, optionally stalling or re-pulsing start mid-operation.
  task automatic applyStimulus(input logic [2:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                               input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                               input int stall_at, input int stall_len, input int restart_at,
                               input string tag);
    logic [31:0] prev_hi, prev_lo;
    int n;
    bit hold_ok, busy_ok, quiet_ok;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = op_i;
    bus.operand_a = a_i;
    bus.operand_b = b_i;
    prev_hi = bus.hi;
    prev_lo = bus.lo;
    @(negedge clk);
    bus.start = 1'b0;
    bus.operand_a = ~a_i;
    bus.operand_b = ~b_i;
    n = 0;
    hold_ok = 1'b1;
    busy_ok = 1'b1;
    while (!bus.done && n < 200) begin
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.hi !== prev_hi || bus.lo !== prev_lo) hold_ok = 1'b0;
      if (n == restart_at) begin
        bus.start = 1'b1;
        bus.op = 3'b000;
        bus.operand_a = 32'h0000_1111;
        bus.operand_b = 32'h0000_0003;
      end
      if (n == restart_at + 1) bus.start = 1'b0;
      if (n == stall_at) bus.clk_enable = 1'b0;
      if (n == stall_at + stall_len) bus.clk_enable = 1'b1;
      @(negedge clk);
      n++;
    end
    bus.clk_enable = 1'b1;
    bus.start = 1'b0;
    checkOutput({tag, " latency"}, 64'(n), 64'(33 + stall_len));
    checkOutput({tag, " busy_during"}, 64'(busy_ok), 64'd1);
    checkOutput({tag, " hilo_hold"}, 64'(hold_ok), 64'd1);
    checkOutput({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
    checkOutput({tag, " hi"}, 64'(bus.hi), 64'(exp_hi));
    checkOutput({tag, " lo"}, 64'(bus.lo), 64'(exp_lo));
    @(negedge clk);
    checkOutput({tag, " done_pulse"}, 64'(bus.done), 64'd0);
    if (restart_at >= 0) begin
      quiet_ok = 1'b1;
      repeat (40) begin
        @(negedge clk);
        if (bus.done || bus.busy) quiet_ok = 1'b0;
      end
      checkOutput({tag, " single_done"}, 64'(quiet_ok), 64'd1);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vecs[0]  = '{3'b000, 32'hFFFF_FFFF, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
    vecs[1]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2]  = '{3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{3'b011, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E};
    vecs[4]  = '{3'b011, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF};
    vecs[5]  = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[6]  = '{3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[7]  = '{3'b000, 32'h0000_0003, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[8]  = '{3'b010, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[9]  = '{3'b010, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003};
    vecs[10] = '{3'b011, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};
    vecs[11] = '{3'b001, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
    vecs[12] = '{3'b010, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[13] = '{3'b000, 32'h0000_0000, 32'h0001_2345, 32'h0000_0000, 32'h0000_0000};

    reset = 1'b0;
    bus.clk_enable = 1'b1;
    bus.start = 1'b0;
    bus.op = 3'b000;
    bus.operand_a = '0;
    bus.operand_b = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset hi", 64'(bus.hi), 64'd0);
    checkOutput("reset lo", 64'(bus.lo), 64'd0);
    checkOutput("reset busy", 64'(bus.busy), 64'd0);
    checkOutput("reset done", 64'(bus.done), 64'd0);
    reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo,
                    -1, 0, -1, $sformatf("vec%0d", i));
    end

    // MTHI then MTLO on consecutive edges.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 3'b100;
    bus.operand_a = 32'h1234_5678;
    @(negedge clk);
    checkOutput("mthi hi", 64'(bus.hi), 64'h1234_5678);
    checkOutput("mthi busy", 64'({bus.busy, bus.done}), 64'd0);
    bus.op = 3'b101;
    bus.operand_a = 32'h9ABC_DEF0;
    @(negedge clk);
    checkOutput("mtlo lo", 64'(bus.lo), 64'h9ABC_DEF0);
    checkOutput("mtlo hi", 64'(bus.hi), 64'h1234_5678);
    checkOutput("mtlo busy", 64'({bus.busy, bus.done}), 64'd0);

    // Op 110 is a no-op: nothing changes.
    bus.op = 3'b110;
    bus.operand_a = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    bus.start = 1'b0;
    checkOutput("noop hilo", {bus.hi, bus.lo}, 64'h1234_5678_9ABC_DEF0);
    checkOutput("noop busy", 64'({bus.busy, bus.done}), 64'd0);

    applyStimulus(3'b000, 32'h0000_0010, 32'h0000_0020, 32'h0000_0000, 32'h0000_0200,
                  -1, 0, 5, "restart");
    applyStimulus(3'b000, 32'hFFFF_FFFF, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                  10, 5, -1, "stall");

    // Asynchronous reset in the middle of a DIV.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 3'b010;
    bus.operand_a = 32'h0000_0064;
    bus.operand_b = 32'h0000_0007;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("async hi", 64'(bus.hi), 64'd0);
    checkOutput("async lo", 64'(bus.lo), 64'd0);
    checkOutput("async busy", 64'(bus.busy), 64'd0);
    checkOutput("async done", 64'(bus.done), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(3'b011, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, -1, 0, -1, "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
